seg_scan_mux: RTL and testbench

Time-multiplexed driver for a common-anode 4-digit seven-segment display. Holds four 4-bit digit codes plus per-digit decimal-point and blank masks. Scans one digit per refresh slot, with a programmable dead-time that suppresses ghosting. Sits directly downstream of the counter/load datapath: it consumes the digit codes that datapath produces and converts each code to an active-low segment pattern internally.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg7_hex_lut.sv | 11 +
 rtl/seg_scan_mux.sv | 132 +++++++++++++
 tb/tb_seg_scan_mux.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg_pkg;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   // Active-low g..a patterns for hex digits 0..F
   localparam logic [6:0] HEX_SEG [0:15] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      BLANK,
      DRIVE
   } phase_e;

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex digit to active-low segment pattern lookup.
module seg7_hex_lut
   import seg_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX_SEG[code_i];

endmodule

// File: rtl/seg_scan_mux.sv
// Multiplexed common-anode 7-segment scanner with dead-time and frame-synced update.
// Optional leading-zero suppression: define LEADING_ZERO_BLANK_EN.
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] din,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_start
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] sh_din_q, disp_din_q;
   logic [NUM_DIGITS-1:0]   sh_dp_q, disp_dp_q;
   logic [NUM_DIGITS-1:0]   sh_blank_q, disp_blank_q;
   logic [NUM_DIGITS-1:0]   an_q;
   logic [7:0]              seg_q;
   logic                    fs_q;

   logic                  wrap, last, boundary;
   phase_e                phase;
   logic [3:0]            code;
   logic                  dp_sel, dark_sel;
   logic [6:0]            lut_seg;
   logic [7:0]            seg_drive;
   logic [NUM_DIGITS-1:0] an_drive;

   assign wrap     = (cnt_q == CW'(REFRESH_DIV - 1));
   assign last     = (idx_q == IW'(NUM_DIGITS - 1));
   assign boundary = en & wrap & last;
   assign cnt_d    = wrap ? '0 : cnt_q + 1'b1;
   assign idx_d    = !wrap ? idx_q : (last ? '0 : idx_q + 1'b1);
   assign phase    = (int'(cnt_q) < BLANK_CYCLES) ? BLANK : DRIVE;

`ifdef LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz;
   logic                  run;

   // Run of unmasked zeros from the most significant digit downwards
   always_comb begin
      lz  = '0;
      run = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         run   = run & (disp_din_q[4*i +: 4] == 4'd0) & ~disp_blank_q[i];
         lz[i] = run;
      end
   end
`endif

   always_comb begin
      code     = '0;
      dp_sel   = 1'b0;
      dark_sel = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            code     = disp_din_q[4*i +: 4];
            dp_sel   = disp_dp_q[i];
`ifdef LEADING_ZERO_BLANK_EN
            dark_sel = disp_blank_q[i] | lz[i];
`else
            dark_sel = disp_blank_q[i];
`endif
         end
      end
   end

   seg7_hex_lut u_lut (
      .code_i (code),
      .seg_o  (lut_seg)
   );

   assign seg_drive = {~dp_sel, dark_sel ? 7'h7F : lut_seg};
   assign an_drive  = ~(NUM_DIGITS'(1) << idx_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         sh_din_q     <= '0;
         sh_dp_q      <= '0;
         sh_blank_q   <= '1;
         disp_din_q   <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= '1;
         an_q         <= '1;
         seg_q        <= SEG_OFF;
         fs_q         <= 1'b0;
      end else begin
         if (load) begin
            sh_din_q   <= din;
            sh_dp_q    <= dp_in;
            sh_blank_q <= blank_in;
         end
         // Display takes the pre-load shadow, so frames are never torn
         if (boundary) begin
            disp_din_q   <= sh_din_q;
            disp_dp_q    <= sh_dp_q;
            disp_blank_q <= sh_blank_q;
         end
         if (en) begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            an_q  <= (phase == DRIVE) ? an_drive : '1;
            seg_q <= (phase == DRIVE) ? seg_drive : SEG_OFF;
            fs_q  <= (cnt_q == '0) && (idx_q == '0);
         end else begin
            an_q  <= '1;
            seg_q <= SEG_OFF;
            fs_q  <= 1'b0;
         end
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux (4 digits, 8-cycle slots, 2 dark).
module tb_seg_scan_mux;

   localparam int ND = 4;
   localparam int RD = 8;
   localparam int BC = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic        load;
   logic [15:0] din;
   logic [3:0]  dp_in;
   logic [3:0]  blank_in;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        frame_start;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0][7:0] s6;

   always #5 clk = ~clk;

   seg_scan_mux #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .load        (load),
      .din         (din),
      .dp_in       (dp_in),
      .blank_in    (blank_in),
      .seg         (seg),
      .an          (an),
      .frame_start (frame_start)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Checks one full frame; entry is the negedge showing the frame_start cycle
   task automatic run_frame(
      input string           tag,
      input logic [3:0][7:0] s,
      input int              a_at,
      input logic [15:0]     a_din,
      input logic [3:0]      a_dp,
      input logic [3:0]      a_bl,
      input int              b_at,
      input logic [15:0]     b_din,
      input logic [3:0]      b_dp,
      input logic [3:0]      b_bl
   );
      logic [3:0] ea;
      logic [7:0] es;
      for (int d = 0; d < ND; d++) begin
         for (int c = 0; c < RD; c++) begin
            ea = (c < BC) ? 4'hF : ~(4'b0001 << d);
            es = (c < BC) ? 8'hFF : s[d];
            chk($sformatf("%s d%0d c%0d an", tag, d, c), {4'h0, an}, {4'h0, ea});
            chk($sformatf("%s d%0d c%0d seg", tag, d, c), seg, es);
            chk($sformatf("%s d%0d c%0d fs", tag, d, c),
                {7'h0, frame_start}, {7'h0, (d == 0 && c == 0)});
            if (d * RD + c == a_at) begin
               din = a_din; dp_in = a_dp; blank_in = a_bl; load = 1'b1;
            end
            if (d * RD + c == b_at) begin
               din = b_din; dp_in = b_dp; blank_in = b_bl; load = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
         end
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      en       = 1'b0;
      load     = 1'b0;
      din      = '0;
      dp_in    = '0;
      blank_in = '0;
`ifdef LEADING_ZERO_BLANK_EN
      s6 = {8'hFF, 8'h7F, 8'hF8, 8'hC0};
`else
      s6 = {8'hC0, 8'h40, 8'hF8, 8'hC0};
`endif
      repeat (2) @(negedge clk);
      chk("rst an", {4'h0, an}, 8'h0F);
      chk("rst seg", seg, 8'hFF);
      chk("rst fs", {7'h0, frame_start}, 8'h00);

      reset_n = 1'b1;
      en      = 1'b1;
      @(negedge clk);

      run_frame("f1", {8'hFF, 8'hFF, 8'hFF, 8'hFF},
                0, 16'h1234, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      run_frame("f2", {8'hF9, 8'hA4, 8'hB0, 8'h99},
                30, 16'h5678, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      run_frame("f3", {8'hF9, 8'hA4, 8'hB0, 8'h99},
                -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      run_frame("f4", {8'h92, 8'h82, 8'hF8, 8'h80},
                5, 16'hEEEE, 4'hF, 4'h0, 6, 16'h9AF0, 4'b0101, 4'b0010);
      run_frame("f5", {8'h90, 8'h08, 8'hFF, 8'h40},
                10, 16'h0070, 4'b0100, 4'h0, -1, 16'h0, 4'h0, 4'h0);
      run_frame("f6", s6,
                -1, 16'h0, 4'h0, 4'h0, -1, 16'h0, 4'h0, 4'h0);

      repeat (19) @(negedge clk);
      chk("pre-hold an", {4'h0, an}, 8'h0B);
      chk("pre-hold seg", seg, s6[2]);
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("hold%0d an", i), {4'h0, an}, 8'h0F);
         chk($sformatf("hold%0d seg", i), seg, 8'hFF);
         chk($sformatf("hold%0d fs", i), {7'h0, frame_start}, 8'h00);
      end
      en = 1'b1;
      for (int c = 4; c < RD; c++) begin
         @(negedge clk);
         chk($sformatf("resume c%0d an", c), {4'h0, an}, 8'h0B);
         chk($sformatf("resume c%0d seg", c), seg, s6[2]);
      end
      @(negedge clk);
      chk("d3 c0 an", {4'h0, an}, 8'h0F);
      @(negedge clk);
      chk("d3 c1 an", {4'h0, an}, 8'h0F);
      @(negedge clk);
      chk("d3 c2 an", {4'h0, an}, 8'h07);
      chk("d3 c2 seg", seg, s6[3]);

      #2 reset_n = 1'b0;
      #1;
      chk("async an", {4'h0, an}, 8'h0F);
      chk("async seg", seg, 8'hFF);
      chk("async fs", {7'h0, frame_start}, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("post fs", {7'h0, frame_start}, 8'h01);
      chk("post an", {4'h0, an}, 8'h0F);
      chk("post seg", seg, 8'hFF);
      @(negedge clk);
      chk("post c1 an", {4'h0, an}, 8'h0F);
      chk("post c1 fs", {7'h0, frame_start}, 8'h00);
      @(negedge clk);
      chk("post c2 an", {4'h0, an}, 8'h0E);
      chk("post c2 seg", seg, 8'hFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
